graph_memory_responder: RTL

- Memory-side responder for the graph-edge read interface (mem_addr / mem_read_enable / mem_read_ready / mem_data).
- Holds the row-major adjacency matrix (MAX_NODES x MAX_NODES edge words) and serves single-word reads after a fixed, parameterised latency.
- A separate synchronous write port lets the testbench or loader fill the matrix before a search starts.
- Sits between the edge-fetching logic and the graph storage; it is the responder for the edge cache's read requests.

---
 rtl/graph_memory_responder_if.sv | 27 ++
 rtl/graph_memory_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/graph_memory_responder_if.sv
// Read/write bus between the edge-fetch client and the graph adjacency-matrix responder.
// The master drives requests and write strobes; the slave returns responses and error pulses.
interface graph_memory_responder_if #(
  parameter int MADDR_WIDTH = 16,
  parameter int MDATA_WIDTH = 32
);
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic                   mem_read_enable;
  logic                   mem_read_ready;
  logic [MDATA_WIDTH-1:0] mem_data;
  logic                   mem_read_error;
  logic                   busy;
  logic                   write_enable;
  logic [MADDR_WIDTH-1:0] write_addr;
  logic [MDATA_WIDTH-1:0] write_data;
  logic                   write_error;

  modport master (
    output mem_addr, mem_read_enable, write_enable, write_addr, write_data,
    input  mem_read_ready, mem_data, mem_read_error, busy, write_error
  );

  modport slave (
    input  mem_addr, mem_read_enable, write_enable, write_addr, write_data,
    output mem_read_ready, mem_data, mem_read_error, busy, write_error
  );
endinterface

// File: rtl/graph_memory_responder.sv
// Adjacency-matrix store that answers single-word reads after a fixed latency.
// A synchronous write port fills the matrix; storage survives reset.
module graph_memory_responder #(
  parameter int MAX_NODES    = 16,
  parameter int MADDR_WIDTH  = 16,
  parameter int MDATA_WIDTH  = 32,
  parameter int READ_LATENCY = 3,
  parameter int BASE_ADDRESS = 0
) (
  input logic clock,
  input logic reset,
  graph_memory_responder_if.slave bus
);
  localparam int WORD_BYTES = MDATA_WIDTH / 8;
  localparam int DEPTH      = MAX_NODES * MAX_NODES;
  localparam int IDX_W      = $clog2(DEPTH);

  localparam logic [MADDR_WIDTH:0] BASE_EXT  = BASE_ADDRESS[MADDR_WIDTH:0];
  localparam logic [MADDR_WIDTH:0] WB_EXT    = WORD_BYTES[MADDR_WIDTH:0];
  localparam logic [MADDR_WIDTH:0] DEPTH_EXT = DEPTH[MADDR_WIDTH:0];
  localparam logic [3:0]           LAT_M1    = 4'(READ_LATENCY - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [MDATA_WIDTH-1:0] mem [DEPTH];

  logic [MADDR_WIDTH-1:0] dec_addr  [2];
  logic                   dec_valid [2];
  logic [IDX_W-1:0]       dec_idx   [2];

  logic [1:0]             state_reg;
  logic [3:0]             cnt_reg;
  logic                   busy_reg;
  logic                   ready_reg;
  logic                   error_reg;
  logic                   invalid_reg;
  logic [MDATA_WIDTH-1:0] data_reg;
  logic [MDATA_WIDTH-1:0] snapshot_reg;
  logic                   write_error_reg;
  logic                   accept;

  assign dec_addr[0] = bus.mem_addr;
  assign dec_addr[1] = bus.write_addr;

  // Port 0 decodes the read address, port 1 the write address; one extra bit keeps underflow exact.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_decode
      logic [MADDR_WIDTH:0] ext;
      logic [MADDR_WIDTH:0] offset;
      logic [MADDR_WIDTH:0] quot;
      logic [MADDR_WIDTH:0] rem;
      assign ext    = {1'b0, dec_addr[gi]};
      assign offset = ext - BASE_EXT;
      assign quot   = offset / WB_EXT;
      assign rem    = offset % WB_EXT;
      assign dec_valid[gi] = (ext >= BASE_EXT) && (rem == '0) && (quot < DEPTH_EXT);
      assign dec_idx[gi]   = quot[IDX_W-1:0];
    end
  endgenerate

  assign accept = (state_reg == IDLE) && bus.mem_read_enable;

  // Snapshot reads the pre-write word, so a same-edge write is not visible to this response.
  always_ff @(posedge clock) begin
    if (bus.write_enable && dec_valid[1]) begin
      mem[dec_idx[1]] <= bus.write_data;
    end
    if (accept) begin
      snapshot_reg <= dec_valid[0] ? mem[dec_idx[0]] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      busy_reg        <= 1'b0;
      ready_reg       <= 1'b0;
      error_reg       <= 1'b0;
      invalid_reg     <= 1'b0;
      data_reg        <= '0;
      write_error_reg <= 1'b0;
    end else begin
      write_error_reg <= bus.write_enable && !dec_valid[1];
      case (state_reg)
        IDLE: begin
          if (accept) begin
            busy_reg    <= 1'b1;
            invalid_reg <= !dec_valid[0];
            cnt_reg     <= LAT_M1;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          // Counter hits zero READ_LATENCY-1 edges after acceptance; the following edge raises ready.
          if (cnt_reg == 4'd0) begin
            ready_reg <= 1'b1;
            error_reg <= invalid_reg;
            data_reg  <= snapshot_reg;
            state_reg <= RESPOND;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESPOND: begin
          ready_reg <= 1'b0;
          error_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read_ready = ready_reg;
  assign bus.mem_data       = data_reg;
  assign bus.mem_read_error = error_reg;
  assign bus.busy           = busy_reg;
  assign bus.write_error    = write_error_reg;
endmodule
